fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Sequencing controller for the dual-issue instruction fetch stage. It owns the fetch stage's stall, flush and redirect-target inputs. It arbitrates between redirect sources: trap and branch mispredict. It also handles boot hold-off, halt/resume, and decode or instruction-memory backpressure. Sits between the EX/trap logic and the fetch stage; all redirects reach fetch through this block.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after boot.
BOOT_CYCLES, 4, cycles stall is held after reset release (range 1..255).
FLUSH_CYCLES, 2, cycles flush is held per redirect (range 1..15; 0 illegal).
STALL_TIMEOUT, 1024, consecutive RUN stall cycles before the watchdog flag sets (range 1..65535).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
trap_req_i  in  1  trap/exception redirect request
trap_vector_i  in  32  trap target address
br_redirect_i  in  1  branch mispredict redirect from EX
br_target_i  in  32  corrected branch target
dec_ready_i  in  1  decode can accept an instruction pair this cycle
imem_ready_i  in  1  instruction memory can serve a read this cycle
halt_req_i  in  1  request fetch halt (level, sampled)
resume_i  in  1  leave HALT
fetch_stall_o  out  1  to fetch stage stall input
fetch_flush_o  out  1  to fetch stage flush input
fetch_target_o  out  32  to fetch stage target address input
state_o  out  2  current FSM state
redirect_cnt_o  out  16  count of trap/branch redirects, saturating
stall_timeout_o  out  1  sticky stall watchdog flag

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high. `rst` has priority over everything, including mid-operation.
- Reset values:
  - state = BOOT (encoding 0); fetch_stall_o = 1; fetch_flush_o = 0.
  - fetch_target_o = RESET_VECTOR.
  - redirect_cnt_o = 0; stall_timeout_o = 0.
  - boot counter = BOOT_CYCLES; flush counter = 0; halt_pend = 0.
- State encodings: BOOT = 0, RUN = 1, FLUSH = 2, HALT = 3.
- Output timing: fetch_flush_o and fetch_target_o are registered. fetch_stall_o is combinational in RUN only; registered in all other states.
- BOOT:
  - stall = 1, flush = 0.
  - Counter decrements each cycle.
  - After BOOT_CYCLES cycles: go to FLUSH with target = RESET_VECTOR; this entry does not count as a redirect.
  - trap_req_i, br_redirect_i and halt_req_i are ignored in BOOT.
- RUN:
  - fetch_stall_o = !dec_ready_i | !imem_ready_i, same cycle; flush = 0.
  - Priority: trap > branch > halt.
  - trap_req_i: next state FLUSH, target latched = trap_vector_i.
  - br_redirect_i (no trap): next state FLUSH, target latched = br_target_i.
  - Trap and branch in the same cycle: trap wins; the branch is dropped.
  - halt_req_i with no redirect: next state HALT.
  - Flush latency from a redirect request: 1 cycle.
- FLUSH:
  - fetch_flush_o = 1 and fetch_stall_o = 1 for FLUSH_CYCLES cycles; fetch_target_o held constant.
  - A new trap/branch arriving in FLUSH: relatch target (trap priority) and reload the counter to FLUSH_CYCLES. The flush is extended, never truncated.
  - halt_req_i seen in FLUSH sets halt_pend.
  - On expiry: go to HALT if halt_pend (then clear halt_pend), else RUN.
- HALT:
  - stall = 1, flush = 0.
  - trap/branch latch a pending target (trap > branch; a later request overwrites) and set a pending flag.
  - resume_i = 1 with halt_req_i = 0: go to FLUSH if pending (pending is then cleared), else RUN.
  - resume_i and halt_req_i both high: stay in HALT.
- redirect_cnt_o:
  - +1 on each trap/branch accepted in RUN, FLUSH or HALT.
  - Saturates at 16'hFFFF; boot entry excluded.
- Stall watchdog:
  - 16-bit counter increments on each RUN cycle with fetch_stall_o = 1.
  - Clears on any non-stalled cycle or on leaving RUN.
  - Reaching STALL_TIMEOUT sets stall_timeout_o; the flag is sticky until rst.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - the 2-bit state type and its encodings (BOOT, RUN, FLUSH, HALT);
  - the address width (32);
  - the default RESET_VECTOR.
- One sub-module, sat_counter (parameterised width, inc/clr, saturating). Used for redirect_cnt_o and for the stall watchdog.
- The FSM and the target latch stay inline.

Test Plan (BOOT_CYCLES=4, FLUSH_CYCLES=2, RESET_VECTOR=0, STALL_TIMEOUT=8):
1. Release rst at cycle 0 -> stall=1 for cycles 0-3; flush=1 with target=0 for cycles 4-5; cycle 6 state_o=1 (RUN) and stall=0.
2. In RUN, trap 0x100 and branch 0x200 in the same cycle -> next 2 cycles flush=1 with target=0x100; then RUN; redirect_cnt_o=1.
3. Branch 0x40 during the 1st FLUSH cycle of a trap to 0x100 -> target becomes 0x40, flush lasts 2 more cycles (3 total); redirect_cnt_o=2.
4. dec_ready_i=0 held in RUN -> stall=1 the same cycle; stall_timeout_o=1 after the 8th stalled cycle; stays 1 after dec_ready_i=1.
5. halt_req_i in RUN -> HALT, stall=1. Then branch 0x80, then resume_i -> FLUSH 2 cycles with target 0x80, then RUN.
6. rst during the 2nd FLUSH cycle -> next cycle state_o=0, flush=0, stall=1, redirect_cnt_o=0, target=0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants
// for the fetch sequencing controller.
package fetch_ctrl_pkg;

  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fc_state_e;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// sat_counter: up counter with clear that
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: boot, redirect, halt and
// backpressure sequencing for fetch.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int BOOT_CYCLES   = 4,
  parameter int FLUSH_CYCLES  = 2,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_vector_i,
  input  logic              br_redirect_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              dec_ready_i,
  input  logic              imem_ready_i,
  input  logic              halt_req_i,
  input  logic              resume_i,
  output logic              fetch_stall_o,
  output logic              fetch_flush_o,
  output logic [ADDR_W-1:0] fetch_target_o,
  output logic [1:0]        state_o,
  output logic [15:0]       redirect_cnt_o,
  output logic              stall_timeout_o
);

  localparam logic [7:0] BOOT_LD  = 8'(BOOT_CYCLES);
  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);
  localparam logic [15:0] WD_LAST = 16'(STALL_TIMEOUT - 1);

  fc_state_e         state_q, state_n;
  logic [7:0]        boot_q, boot_n;
  logic [3:0]        fcnt_q, fcnt_n;
  logic [ADDR_W-1:0] tgt_q, tgt_n;
  logic [ADDR_W-1:0] ptgt_q, ptgt_n;
  logic              pend_q, pend_n;
  logic              hp_q, hp_n;
  logic              stall_q, flush_q;
  logic              to_q;

  logic              redir;
  logic [ADDR_W-1:0] rtgt;
  logic              run_stall;
  logic              in_run;
  logic              wd_inc;
  logic [15:0]       wd_cnt;

  assign redir = trap_req_i | br_redirect_i;
  assign rtgt  = trap_req_i ? trap_vector_i : br_target_i;

  assign in_run    = (state_q == RUN);
  assign run_stall = ~dec_ready_i | ~imem_ready_i;
  assign wd_inc    = in_run & run_stall;

  always_comb begin
    state_n = state_q;
    boot_n  = boot_q;
    fcnt_n  = fcnt_q;
    tgt_n   = tgt_q;
    ptgt_n  = ptgt_q;
    pend_n  = pend_q;
    hp_n    = hp_q;
    unique case (state_q)
      BOOT: begin
        if (boot_q <= 8'd1) begin
          state_n = FLUSH;
          fcnt_n  = FLUSH_LD;
          tgt_n   = RESET_VECTOR;
        end else begin
          boot_n = boot_q - 8'd1;
        end
      end
      RUN: begin
        if (redir) begin
          state_n = FLUSH;
          fcnt_n  = FLUSH_LD;
          tgt_n   = rtgt;
        end else if (halt_req_i) begin
          state_n = HALT;
        end
      end
      FLUSH: begin
        if (halt_req_i) hp_n = 1'b1;
        // A redirect here restarts the window.
        if (redir) begin
          tgt_n  = rtgt;
          fcnt_n = FLUSH_LD;
        end else if (fcnt_q <= 4'd1) begin
          state_n = (hp_q | halt_req_i) ? HALT : RUN;
          hp_n    = 1'b0;
          fcnt_n  = '0;
        end else begin
          fcnt_n = fcnt_q - 4'd1;
        end
      end
      HALT: begin
        if (redir) begin
          pend_n = 1'b1;
          ptgt_n = rtgt;
        end
        if (resume_i && !halt_req_i) begin
          if (pend_q | redir) begin
            state_n = FLUSH;
            fcnt_n  = FLUSH_LD;
            tgt_n   = redir ? rtgt : ptgt_q;
            pend_n  = 1'b0;
          end else begin
            state_n = RUN;
          end
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      boot_q  <= BOOT_LD;
      fcnt_q  <= '0;
      tgt_q   <= RESET_VECTOR;
      ptgt_q  <= RESET_VECTOR;
      pend_q  <= 1'b0;
      hp_q    <= 1'b0;
      stall_q <= 1'b1;
      flush_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      boot_q  <= boot_n;
      fcnt_q  <= fcnt_n;
      tgt_q   <= tgt_n;
      ptgt_q  <= ptgt_n;
      pend_q  <= pend_n;
      hp_q    <= hp_n;
      stall_q <= (state_n != RUN);
      flush_q <= (state_n == FLUSH);
      if (wd_inc && (wd_cnt >= WD_LAST)) to_q <= 1'b1;
    end
  end

  sat_counter #(.W(16)) u_redir_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redir & (state_q != BOOT)),
    .clr (1'b0),
    .cnt (redirect_cnt_o)
  );

  sat_counter #(.W(16)) u_wd_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wd_inc),
    .clr (~wd_inc),
    .cnt (wd_cnt)
  );

  assign fetch_stall_o   = in_run ? run_stall : stall_q;
  assign fetch_flush_o   = flush_q;
  assign fetch_target_o  = tgt_q;
  assign state_o         = state_q;
  assign stall_timeout_o = to_q;

endmodule
